icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-cache responder that serves the pre-fetch stage's req/addr/addr_ok handshake and returns one aligned doubleword (two instructions) per accepted request.
- Direct-mapped, flop-based data/tag arrays. Blocking: at most one miss in flight.
- On a miss, refills a full line from the memory side over a burst read interface, then answers the pending request.
- Sits between the pre-fetch/fetch stages and the AXI bridge read channel.

Parameters:
- SETS, 128, number of lines (power of two); index = addr[5+log2(SETS)-1:5].
- LINE_WORDS, 8, 32-bit words per line (fixed 32 B line); offset = addr[4:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  fetch request valid
- addr  in  32  fetch address; addr[2:0] ignored (doubleword aligned)
- addr_ok  out  1  request accepted this cycle (req && addr_ok = handshake)
- data_ok  out  1  rdata valid for oldest accepted request
- rdata  out  64  {word at addr[4:3]*2+1, word at addr[4:3]*2}
- rd_req  out  1  line refill request
- rd_addr  out  32  line-aligned refill address, low 5 bits zero
- rd_rdy  in  1  memory accepts rd_req
- ret_valid  in  1  refill beat valid
- ret_last  in  1  final refill beat
- ret_data  in  32  refill beat data, ascending word order

Behaviour:
- Tag = addr[31:5+log2(SETS)]. Arrays per set: valid bit, tag, LINE_WORDS x 32 data.
- Reset: all valid bits 0, state IDLE, addr_ok=0, data_ok=0, rd_req=0, rdata=0, beat counter 0. Tag and data arrays are not reset.
- States: IDLE, LOOKUP, MISS, REFILL, RESPOND.
- IDLE:
  - addr_ok = req.
  - On handshake, latch addr into req_addr and go to LOOKUP.
- LOOKUP:
  - Compare valid[idx] and tag against req_addr, combinationally from the arrays.
  - Hit: data_ok=1 and rdata from array this cycle; 1-cycle hit latency after the handshake. addr_ok = req in the same cycle (pipelined accept). If accepted, stay in LOOKUP with the new address; otherwise go to IDLE.
  - Miss: data_ok=0, addr_ok=0; go to MISS.
- MISS:
  - rd_req=1, rd_addr={req_addr[31:5],5'b0}.
  - rd_req and rd_addr stay stable until rd_rdy. On rd_req && rd_rdy, go to REFILL and clear the beat counter.
- REFILL:
  - Each ret_valid writes ret_data into a line buffer at index cnt, then cnt++ (width log2(LINE_WORDS), wraps).
  - On ret_valid && ret_last: commit the line buffer (including the final beat) to data[idx], write tag[idx], set valid[idx]=1, go to RESPOND.
  - ret_last arriving before LINE_WORDS beats is a protocol error. Commit whatever was buffered; this is not checked.
- RESPOND:
  - data_ok=1, rdata taken from the line buffer (the array is not re-read).
  - addr_ok=0. Go to IDLE.
- Outside REFILL, ret_valid is ignored. addr_ok is never asserted in MISS, REFILL or RESPOND.
- A refill always overwrites the set, evicting any valid line (no writeback; I-cache is read-only).
- Reset mid-operation (any state, including a partial refill): return to the reset state next cycle. The partially filled line is discarded and the valid bit is not set. Trailing ret beats are ignored because the block is now in IDLE.
- data_ok is asserted exactly once per accepted request, in acceptance order, with no reordering.
- rdata is don't-care when data_ok=0; the bench must not check it.

Test Plan:
- Cold miss: after reset, req addr=0xbfc00000.
  - Expect addr_ok same cycle; LOOKUP miss; rd_req with rd_addr=0xbfc00000 until rd_rdy.
  - Feed 8 beats 0x1000..0x1007 with ret_last on the 8th; next cycle data_ok=1, rdata=0x00001001_00001000.
- Hit: then req addr=0xbfc00018.
  - Expect data_ok exactly one cycle after the handshake, rdata=0x00001007_00001006, rd_req never asserted.
- Back-to-back hits: req held high with 0xbfc00000, 0xbfc00008, 0xbfc00010.
  - Expect addr_ok every cycle, then data_ok on 3 consecutive cycles with rdata ..1001_..1000, ..1003_..1002, ..1005_..1004.
- Conflict eviction: req 0xbfc01000 (same index 0, SETS=128).
  - Expect a miss and refill with rd_addr=0xbfc01000.
  - Subsequent 0xbfc00000 misses again and re-refills.
- rd_rdy stall: hold rd_rdy=0 for 5 cycles during MISS.
  - Expect rd_req=1 with rd_addr constant throughout, addr_ok=0, data_ok=0.
- Reset mid-refill: assert reset after 3 of 8 beats, then re-request the same address.
  - Expect a miss (valid not set) and a fresh rd_req.
  - Stray ret_valid beats during and after reset cause no data_ok.

Source files
------------

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped blocking I-cache answering fetch requests with one doubleword each.
module icache_responder #(
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [63:0] rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 5 - IW;
  localparam int CW = $clog2(LINE_WORDS);
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESPOND} state_e;
  state_e         state_q;
  logic [31:3]    req_addr_q;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]  tag_q  [SETS];
  logic [31:0]    data_q [SETS][LINE_WORDS];
  logic [31:0]    line_q [LINE_WORDS];
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [CW-1:0]  lo_w, hi_w;
  logic           hit;
  logic           unused_addr;
  assign unused_addr = ^addr[2:0];
  assign idx  = req_addr_q[5+IW-1:5];
  assign tag  = req_addr_q[31:5+IW];
  assign lo_w = {req_addr_q[4:3], 1'b0};
  assign hi_w = {req_addr_q[4:3], 1'b1};
  assign hit  = state_q == LOOKUP && valid_q[idx] && tag_q[idx] == tag;
  assign addr_ok = req && (state_q == IDLE || hit);
  assign data_ok = hit || state_q == RESPOND;
  // A hit reads the array; the post-refill answer comes from the line buffer.
  assign rdata = hit ? {data_q[idx][hi_w], data_q[idx][lo_w]}
               : state_q == RESPOND ? {line_q[hi_w], line_q[lo_w]} : 64'd0;
  assign rd_req  = state_q == MISS;
  assign rd_addr = {req_addr_q[31:5], 5'd0};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          req_addr_q <= addr[31:3];
          state_q    <= LOOKUP;
        end
        LOOKUP: if (!hit) state_q <= MISS;
          else if (req) req_addr_q <= addr[31:3];
          else state_q <= IDLE;
        MISS: if (rd_rdy) begin
          state_q <= REFILL;
          cnt_q   <= '0;
        end
        REFILL: if (ret_valid) begin
          line_q[cnt_q] <= ret_data;
          cnt_q         <= cnt_q + 1'b1;
          if (ret_last) begin
            for (int i = 0; i < LINE_WORDS; i++)
              data_q[idx][i] <= CW'(i) == cnt_q ? ret_data : line_q[i];
            tag_q[idx]   <= tag;
            valid_q[idx] <= 1'b1;
            state_q      <= RESPOND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: scoreboard bench for icache_responder against a bench-side memory model.
module tb_icache_responder;
  logic        clk = 0, reset = 1, req = 0, rd_rdy = 0, ret_valid = 0, ret_last = 0;
  logic [31:0] addr = 0, ret_data = 0, rd_addr;
  logic        addr_ok, data_ok, rd_req;
  logic [63:0] rdata;
  int          n_cmp = 0, n_bad = 0, n_rdreq = 0;
  logic [63:0] sb [$];
  icache_responder dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000 * ({28'd0, a[15:12]} + 32'd1) + {29'd0, a[4:2]};
  endfunction
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (rd_req) n_rdreq++;
      if (data_ok) begin
        if (sb.size() == 0) chk("spurious_data_ok", 1, 0);
        else chk("rdata", rdata, sb.pop_front());
      end
      if (req && addr_ok) sb.push_back({mem(addr | 32'd4), mem(addr & ~32'd4)});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] a);
    bit ok = 0;
    req = 1;
    addr = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = addr_ok;
      tick();
    end
    req = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  task automatic serve(input logic [31:0] line, input int stall, input int beats, input bit last);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rd_req;
      if (!seen) tick();
    end
    if (!seen) chk("rd_req_timeout", 0, 1);
    chk("rd_addr", rd_addr, line);
    for (int s = 0; s < stall; s++) begin
      tick();
      req = 1;
      addr = 32'h1234_5678;
      @(negedge clk);
      chk("stall_rd_req", rd_req, 1);
      chk("stall_rd_addr", rd_addr, line);
      chk("stall_addr_ok", addr_ok, 0);
      chk("stall_data_ok", data_ok, 0);
    end
    tick();
    req = 0;
    rd_rdy = 1;
    @(negedge clk);
    chk("rdy_rd_req", rd_req, 1);
    tick();
    rd_rdy = 0;
    for (int i = 0; i < beats; i++) begin
      ret_valid = 1;
      ret_data = mem(line + 32'(4 * i));
      ret_last = last && i == beats - 1;
      tick();
    end
    ret_valid = 0;
    ret_last = 0;
    if (last) begin
      @(negedge clk);
      chk("respond_data_ok", data_ok, 1);
      tick();
    end
  endtask
  initial begin
    int rq0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rd_req", rd_req, 0);
    tick();
    reset = 0;
    fetch(32'hbfc00000);
    serve(32'hbfc00000, 0, 8, 1);
    rq0 = n_rdreq;
    fetch(32'hbfc00018);
    @(negedge clk);
    chk("hit_latency", data_ok, 1);
    tick();
    req = 1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'hbfc00000 + 32'(8 * i);
      @(negedge clk);
      chk("b2b_addr_ok", addr_ok, 1);
      if (i > 0) chk("b2b_data_ok", data_ok, 1);
      tick();
    end
    req = 0;
    @(negedge clk);
    chk("b2b_data_ok", data_ok, 1);
    tick();
    chk("hit_no_rd_req", n_rdreq, rq0);
    fetch(32'hbfc01000);
    serve(32'hbfc01000, 0, 8, 1);
    fetch(32'hbfc00000);
    serve(32'hbfc00000, 5, 8, 1);
    fetch(32'hbfc01008);
    serve(32'hbfc01000, 0, 3, 0);
    ret_valid = 1;
    ret_data = 32'hdead_beef;
    reset = 1;
    repeat (2) tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      ret_last = i == 2;
      @(negedge clk);
      chk("stray_data_ok", data_ok, 0);
      tick();
    end
    ret_valid = 0;
    ret_last = 0;
    fetch(32'hbfc01008);
    serve(32'hbfc01000, 0, 8, 1);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end
endmodule
